// File: rtl/tos_link_tx_sched_if.sv
// Requester-side and link-side signals of the 3-of-6 link transmit scheduler.
// The master drives requests and the link acknowledge; the slave is the scheduler.
interface tos_link_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*24-1:0] payload_in;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic                  done;
  logic [5:0]            link_data;
  logic                  link_ack;

  modport master (
    output req, payload_in, link_ack,
    input  grant, busy, done, link_data
  );

  modport slave (
    input  req, payload_in, link_ack,
    output grant, busy, done, link_data
  );
endinterface

// File: rtl/tos_link_tx_sched.sv
// Round-robin transmit scheduler: captures one requester's 24-bit payload, encodes
// it as eight 3-of-6 symbols and sends them with a four-phase return-to-null handshake.

module three_of_six_encoder (
  input  logic [23:0] data,
  output logic [47:0] cw
);
  // Each 3-bit group plus its complement always carries exactly three ones,
  // so no symbol can ever alias the all-zero null spacer.
  for (genvar k = 0; k < 8; k++) begin : g_sym
    assign cw[6*k+5 -: 3] = data[3*k+2 -: 3];
    assign cw[6*k+2 -: 3] = ~data[3*k+2 -: 3];
  end
endmodule

module tos_link_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  tos_link_tx_sched_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DATA, S_NULL} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [2:0]              idx_q, idx_d;
  logic [23:0]             pay_q, pay_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [5:0]              ld_q, ld_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    ack_s;
  logic [NUM_REQ-1:0][23:0] pay_in;
  logic [7:0][5:0]         sym;
  logic                    win_vld;
  logic [PW-1:0]           win_idx;

  assign pay_in = bus.payload_in;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.link_ack};
  assign ack_s  = sync_q[SYNC_STAGES-1];

  three_of_six_encoder u_enc (
    .data (pay_q),
    .cw   (sym)
  );

  // Scan from the highest offset down so the candidate closest to ptr is kept last.
  always_comb begin
    int            cand;
    logic [PW-1:0] cidx;
    cand    = 0;
    cidx    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int off = NUM_REQ-1; off >= 0; off--) begin
      cand = (int'(ptr_q) + off) % NUM_REQ;
      cidx = PW'(cand);
      if (bus.req[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    grant_d = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ld_d    = ld_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          pay_d   = pay_in[win_idx];
          grant_d = NUM_REQ'(1) << win_idx;
          ptr_d   = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_d    = sym[0];
        idx_d   = 3'd0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (ack_s) begin
          ld_d    = 6'd0;
          state_d = S_NULL;
        end
      end
      S_NULL: begin
        if (!ack_s) begin
          if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            ld_d    = sym[idx_q + 3'd1];
            state_d = S_DATA;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= 3'd0;
      pay_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ld_q    <= 6'd0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ld_q    <= ld_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.link_data = ld_q;
endmodule

// File: tb/tb_tos_link_tx_sched.sv
// Bench for tos_link_tx_sched: two instances (SYNC_STAGES 2 and 3) driven identically,
// checked each cycle against a packet/phase-sequence model of the link protocol.
module tb_tos_link_tx_sched;
  localparam int N = 4;
  localparam int L = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [L-1:0][N-1:0]    req_r;
  logic [L-1:0][N*24-1:0] pay_r;
  logic [L-1:0]           glitch;
  int                     rx_extra [L];
  bit                     hold;

  logic [L-1:0][N-1:0] gnt_w;
  logic [L-1:0]        busy_w, done_w, ack_w;
  logic [L-1:0][5:0]   ld_w;

  // Model: a packet is the 16-entry sequence sym0,0,sym1,0,...,sym7,0; m_pos walks it.
  int              m_ptr  [L];
  int              m_pos  [L];
  bit              m_act  [L];
  bit              m_load [L];
  logic [7:0][5:0] m_sym  [L];
  logic [7:0]      hist   [L];
  logic [N-1:0]    e_gnt  [L];
  logic            e_busy [L];
  logic            e_done [L];
  logic [5:0]      e_ld   [L];

  logic [5:0]   sym_log [L][0:1023];
  logic [N-1:0] gnt_log [L][0:255];
  int           log_n   [L];
  int           glog_n  [L];
  int           ndone   [L];
  int           hold_cnt[L];
  int           gl_n    [L];
  logic [5:0]   prev_ld [L];

  for (genvar g = 0; g < L; g++) begin : g_lane
    tos_link_tx_sched_if #(.NUM_REQ(N)) bus ();
    logic rx_ack;

    assign bus.req        = req_r[g];
    assign bus.payload_in = pay_r[g];
    assign bus.link_ack   = rx_ack | glitch[g];
    assign gnt_w[g]       = bus.grant;
    assign busy_w[g]      = bus.busy;
    assign done_w[g]      = bus.done;
    assign ld_w[g]        = bus.link_data;
    assign ack_w[g]       = bus.link_ack;

    tos_link_tx_sched #(.NUM_REQ(N), .SYNC_STAGES(2 + g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Receiver: ack after a random delay on a symbol, release after a random delay on null.
    initial begin
      rx_ack = 1'b0;
      forever begin
        wait (bus.link_data != 6'd0);
        repeat ($urandom_range(0, 3) + rx_extra[g]) @(posedge clk);
        #3 rx_ack = 1'b1;
        wait (bus.link_data == 6'd0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #3 rx_ack = 1'b0;
      end
    end
  end

  task automatic mreset(input int l);
    m_ptr[l] = 0;  m_pos[l] = 0;  m_act[l] = 1'b0; m_load[l] = 1'b0;
    hist[l]  = '0; e_gnt[l] = '0; e_busy[l] = 1'b0; e_done[l] = 1'b0; e_ld[l] = 6'd0;
  endtask

  task automatic mstep(input int l);
    bit          used;
    int          c;
    logic [23:0] p;
    used    = hist[l][1 + l];  // acknowledge as seen through 2+l sampling stages
    hist[l] = {hist[l][6:0], ack_w[l]};
    e_gnt[l]  = '0;
    e_done[l] = 1'b0;
    if (!m_act[l]) begin
      for (int off = 0; off < N; off++) begin
        c = (m_ptr[l] + off) % N;
        if (req_r[l][c]) begin
          p = pay_r[l][24*c +: 24];
          for (int k = 0; k < 8; k++) m_sym[l][k] = {p[3*k+2 -: 3], ~p[3*k+2 -: 3]};
          e_gnt[l][c] = 1'b1;
          e_busy[l]   = 1'b1;
          m_act[l]    = 1'b1;
          m_load[l]   = 1'b1;
          m_ptr[l]    = (c + 1) % N;
          break;
        end
      end
    end else if (m_load[l]) begin
      m_load[l] = 1'b0;
      m_pos[l]  = 0;
      e_ld[l]   = m_sym[l][0];
    end else if (m_pos[l] % 2 == 0) begin
      if (used) begin
        e_ld[l]  = 6'd0;
        m_pos[l] = m_pos[l] + 1;
      end
    end else if (!used) begin
      if (m_pos[l] == 15) begin
        m_act[l]  = 1'b0;
        e_busy[l] = 1'b0;
        e_done[l] = 1'b1;
      end else begin
        m_pos[l] = m_pos[l] + 1;
        e_ld[l]  = m_sym[l][m_pos[l] / 2];
      end
    end
  endtask

  initial begin
    for (int l = 0; l < L; l++) mreset(l);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int l = 0; l < L; l++) begin
        if (!rst_n) mreset(l);
        else        mstep(l);
      end
    end
  end

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", nm, l, $time, act, exp);
    end
  endtask

  task automatic cmp();
    for (int l = 0; l < L; l++) begin
      chk("grant", l, 32'(gnt_w[l]), 32'(e_gnt[l]));
      chk("busy", l, 32'(busy_w[l]), 32'(e_busy[l]));
      chk("done", l, 32'(done_w[l]), 32'(e_done[l]));
      chk("link_data", l, 32'(ld_w[l]), 32'(e_ld[l]));
      if (ld_w[l] != 6'd0) chk("popcount", l, $countones(ld_w[l]), 3);
      if (ld_w[l] != 6'd0 && prev_ld[l] == 6'd0 && log_n[l] < 1024) begin
        sym_log[l][log_n[l]] = ld_w[l];
        log_n[l]++;
      end
      if (gnt_w[l] != '0 && glog_n[l] < 256) begin
        gnt_log[l][glog_n[l]] = gnt_w[l];
        glog_n[l]++;
      end
      prev_ld[l] = ld_w[l];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp();
    for (int l = 0; l < L; l++) begin
      if (done_w[l] === 1'b1) ndone[l]++;
      if (!hold && gnt_w[l] != '0) req_r[l] = req_r[l] & ~gnt_w[l];
    end
  endtask

  // mode 0 plain, 1 stall ack on symbol 3, 2 inject ack glitches, 3 reset during symbol 5
  task automatic run(input int want, input int budget, input int mode);
    int           cyc;
    bit           fin;
    logic [L-1:0] gm;
    cyc = 0;
    for (int l = 0; l < L; l++) begin ndone[l] = 0; hold_cnt[l] = 0; gl_n[l] = 0; end
    while (1) begin
      fin = 1'b1;
      for (int l = 0; l < L; l++) begin
        if (ndone[l] < want) fin = 1'b0;
        else req_r[l] = '0;
      end
      if (fin) break;
      if (cyc >= budget) begin
        checks++; errs++;
        $display("FAIL timeout mode%0d: done counts %0d/%0d, expected %0d", mode, ndone[0], ndone[1], want);
        break;
      end
      tick();
      cyc++;
      if (mode == 1) begin
        for (int l = 0; l < L; l++) begin
          if (m_act[l] && !m_load[l] && m_pos[l] == 5) rx_extra[l] = 20;
          if (m_pos[l] >= 7) rx_extra[l] = 0;
          if (m_act[l] && !m_load[l] && m_pos[l] == 6 && ld_w[l] != 6'd0) hold_cnt[l]++;
        end
      end else if (mode == 2) begin
        gm = '0;
        for (int l = 0; l < L; l++)
          if (m_act[l] && !m_load[l] && m_pos[l] == 4 && gl_n[l] < 2 && ack_w[l] == 1'b0) begin
            gm[l] = 1'b1;
            gl_n[l]++;
          end
        if (gm != '0) begin
          #1 glitch = gm;
          #3 glitch = '0;
        end
      end else if (mode == 3 && m_act[0] && !m_load[0] && m_pos[0] == 10) begin
        #3 rst_n = 1'b0;
        #1;
        for (int l = 0; l < L; l++) begin
          chk("async_link_data", l, 32'(ld_w[l]), 0);
          chk("async_busy", l, 32'(busy_w[l]), 0);
        end
        break;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  int          s0 [L];
  int          gs0[L];
  logic [23:0] p1;
  logic [3:0]  rr;
  logic [5:0]  exp_sym;

  initial begin
    req_r = '0; pay_r = '0; glitch = '0; hold = 1'b0;
    for (int l = 0; l < L; l++) begin
      rx_extra[l] = 0; log_n[l] = 0; glog_n[l] = 0; ndone[l] = 0; prev_ld[l] = 6'd0;
      hold_cnt[l] = 0; gl_n[l] = 0;
    end
    tick();
    tick();
    #2 rst_n = 1'b1;

    // single requester 0, all-zero payload
    for (int l = 0; l < L; l++) begin
      pay_r[l] = {24'($urandom), 24'($urandom), 24'($urandom), 24'h000000};
      req_r[l] = 4'b0001; s0[l] = log_n[l]; gs0[l] = glog_n[l];
    end
    run(1, 800, 0);
    for (int l = 0; l < L; l++) begin
      chk("t1_symbol_count", l, log_n[l] - s0[l], 8);
      chk("t1_grant", l, 32'(gnt_log[l][gs0[l]]), 32'h1);
      for (int k = 0; k < 8; k++) chk("t1_symbol", l, 32'(sym_log[l][s0[l] + k]), 32'h07);
    end

    // requester 2, all-ones payload
    for (int l = 0; l < L; l++) begin
      pay_r[l] = {24'($urandom), 24'hFFFFFF, 24'($urandom), 24'($urandom)};
      req_r[l] = 4'b0100; s0[l] = log_n[l]; gs0[l] = glog_n[l];
    end
    run(1, 800, 0);
    for (int l = 0; l < L; l++) begin
      chk("t2_grant", l, 32'(gnt_log[l][gs0[l]]), 32'h4);
      for (int k = 0; k < 8; k++) chk("t2_symbol", l, 32'(sym_log[l][s0[l] + k]), 32'h38);
    end

    // all requesting, held: round-robin from pointer 0 after reset
    do_reset();
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < N; i++) pay_r[l][24*i +: 24] = {4'(i + 1), 20'($urandom)};
      req_r[l] = 4'b1111; gs0[l] = glog_n[l];
    end
    hold = 1'b1;
    run(5, 3000, 0);
    hold = 1'b0;
    for (int l = 0; l < L; l++) begin
      chk("t3_grant0", l, 32'(gnt_log[l][gs0[l]]),     32'h1);
      chk("t3_grant1", l, 32'(gnt_log[l][gs0[l] + 1]), 32'h2);
      chk("t3_grant2", l, 32'(gnt_log[l][gs0[l] + 2]), 32'h4);
      chk("t3_grant3", l, 32'(gnt_log[l][gs0[l] + 3]), 32'h8);
      chk("t3_grant4", l, 32'(gnt_log[l][gs0[l] + 4]), 32'h1);
    end

    // slow receiver on symbol 3
    for (int l = 0; l < L; l++) begin
      pay_r[l] = {4{24'($urandom)}}; req_r[l] = 4'b0001; s0[l] = log_n[l];
    end
    run(1, 1500, 1);
    for (int l = 0; l < L; l++) begin
      chk("t4_symbol3_held_20", l, 32'(hold_cnt[l] >= 20), 1);
      chk("t4_symbol_count", l, log_n[l] - s0[l], 8);
    end

    // reset during symbol 5, then requester 1
    for (int l = 0; l < L; l++) begin
      pay_r[l] = {4{24'($urandom)}}; req_r[l] = 4'b0001;
    end
    run(1, 1500, 3);
    req_r = '0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    p1 = 24'($urandom);
    exp_sym = {p1[2:0], ~p1[2:0]};
    for (int l = 0; l < L; l++) begin
      pay_r[l] = {24'($urandom), 24'($urandom), p1, 24'($urandom)};
      req_r[l] = 4'b0010; s0[l] = log_n[l]; gs0[l] = glog_n[l];
    end
    run(1, 800, 0);
    for (int l = 0; l < L; l++) begin
      chk("t5_grant", l, 32'(gnt_log[l][gs0[l]]), 32'h2);
      chk("t5_symbol0", l, 32'(sym_log[l][s0[l]]), 32'(exp_sym));
    end

    // sub-cycle acknowledge glitches during a data phase
    for (int l = 0; l < L; l++) begin
      pay_r[l] = {4{24'($urandom)}}; req_r[l] = 4'b0001; s0[l] = log_n[l]; rx_extra[l] = 6;
    end
    run(1, 2500, 2);
    for (int l = 0; l < L; l++) begin
      rx_extra[l] = 0;
      chk("t6_symbol_count", l, log_n[l] - s0[l], 8);
    end

    // random request patterns and payloads
    repeat (6) begin
      rr = 4'($urandom_range(1, 15));
      p1 = 24'($urandom);
      for (int l = 0; l < L; l++) begin
        req_r[l] = rr;
        for (int i = 0; i < N; i++) pay_r[l][24*i +: 24] = p1 ^ 24'($urandom);
      end
      run($countones(rr), 4000, 0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
